// File: rtl/ins_mem_loader.sv
// Instruction memory loader: packs a big-endian byte stream into 32-bit words
// and writes them to consecutive word addresses while holding the CPU.
module ins_mem_loader #(
  parameter int ADR_W     = 12,
  parameter int MAX_WORDS = 4001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ADR_W-1:0] base_adr,
  input  logic [ADR_W-1:0] len,
  input  logic             abort,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [ADR_W-1:0] mem_adr,
  output logic [31:0]      mem_wdata,
  output logic             busy,
  output logic             cpu_hold,
  output logic             done,
  output logic             aborted,
  output logic [31:0]      checksum
);

  // state   | meaning
  // S_IDLE  | waiting for start, no load has run or last one was aborted
  // S_LOAD  | accepting stream bytes into the word buffer
  // S_WRITE | one-cycle memory write of the assembled word
  // S_DONE  | load finished, waiting for the next start
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  localparam logic [ADR_W-1:0] MaxLen = ADR_W'(MAX_WORDS);

  state_t           state_q, state_d;
  logic [ADR_W-1:0] base_q, base_d;
  logic [ADR_W-1:0] len_q, len_d;
  logic [ADR_W-1:0] words_q, words_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      word_q, word_d;
  logic [ADR_W-1:0] last_adr_q, last_adr_d;
  logic [31:0]      last_data_q, last_data_d;
  logic [31:0]      checksum_q, checksum_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             byte_ready_q, byte_ready_d;
  logic             busy_q, busy_d;

  logic [ADR_W-1:0] cur_adr;
  logic [ADR_W-1:0] len_clamp;
  logic [ADR_W-1:0] words_inc;

  assign cur_adr   = base_q + words_q;
  assign len_clamp = (len > MaxLen) ? MaxLen : len;
  assign words_inc = words_q + 1'b1;

  // The write strobe is gated by abort in the same cycle so a late abort
  // cancels the pending write; address/data outputs only move on a real write.
  assign mem_we     = (state_q == S_WRITE) && !abort;
  assign mem_adr    = mem_we ? cur_adr : last_adr_q;
  assign mem_wdata  = mem_we ? word_q  : last_data_q;
  assign byte_ready = byte_ready_q;
  assign busy       = busy_q;
  assign cpu_hold   = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign checksum   = checksum_q;

  // Next-state and next-output computation.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    words_d     = words_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    last_adr_d  = last_adr_q;
    last_data_d = last_data_q;
    checksum_d  = checksum_q;
    done_d      = done_q;
    aborted_d   = aborted_q;

    if (abort) begin
      state_d    = S_IDLE;
      byte_cnt_d = 2'd0;
      if (state_q == S_LOAD || state_q == S_WRITE) begin
        aborted_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            base_d     = base_adr;
            len_d      = len_clamp;
            words_d    = '0;
            byte_cnt_d = 2'd0;
            done_d     = 1'b0;
            aborted_d  = 1'b0;
            checksum_d = '0;
            if (len_clamp == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (byte_valid) begin
            case (byte_cnt_q)
              2'd0:    word_d[31:24] = byte_data;
              2'd1:    word_d[23:16] = byte_data;
              2'd2:    word_d[15:8]  = byte_data;
              default: word_d[7:0]   = byte_data;
            endcase
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_d = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          last_adr_d  = cur_adr;
          last_data_d = word_q;
          checksum_d  = checksum_q + word_q;
          words_d     = words_inc;
          if (words_inc == len_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    byte_ready_d = (state_d == S_LOAD);
    busy_d       = (state_d == S_LOAD) || (state_d == S_WRITE);
  end

  // All loader state, including registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      len_q        <= '0;
      words_q      <= '0;
      byte_cnt_q   <= 2'd0;
      word_q       <= '0;
      last_adr_q   <= '0;
      last_data_q  <= '0;
      checksum_q   <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      len_q        <= len_d;
      words_q      <= words_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      last_adr_q   <= last_adr_d;
      last_data_q  <= last_data_d;
      checksum_q   <= checksum_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
    end
  end

endmodule
